axi_mem_arbiter: RTL

//  N-port round-robin arbiter and AXI3 master bridge. Generalises the single i/d-cache select mux and the

---
 rtl/axi_mem_arbiter.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/axi_mem_arbiter.sv
// N-port round-robin arbiter feeding a single-outstanding AXI3 master.
// Each port issues INCR bursts of up to MAX_LEN beats: reads go AR->R, writes go AW->W->B.
module axi_mem_arbiter #(
    parameter int NUM_PORTS = 2,
    parameter int MAX_LEN   = 8,
    parameter int LW        = 3
) (
    input  logic                           aclk,
    input  logic                           aresetn,
    input  logic [NUM_PORTS-1:0]           p_req,
    input  logic [NUM_PORTS-1:0]           p_write,
    input  logic [NUM_PORTS-1:0][31:0]     p_addr,
    input  logic [NUM_PORTS-1:0][2:0]      p_size,
    input  logic [NUM_PORTS-1:0][LW-1:0]   p_len,
    input  logic [NUM_PORTS-1:0][3:0]      p_strb,
    input  logic [NUM_PORTS-1:0][31:0]     p_wdata,
    output logic [NUM_PORTS-1:0]           p_wnext,
    output logic [NUM_PORTS-1:0]           p_rvalid,
    output logic [31:0]                    p_rdata,
    output logic [NUM_PORTS-1:0]           p_done,
    output logic [3:0]                     arid,
    output logic [31:0]                    araddr,
    output logic [7:0]                     arlen,
    output logic [2:0]                     arsize,
    output logic [1:0]                     arburst,
    output logic                           arvalid,
    input  logic                           arready,
    input  logic [31:0]                    rdata,
    input  logic                           rlast,
    input  logic                           rvalid,
    output logic                           rready,
    output logic [3:0]                     awid,
    output logic [31:0]                    awaddr,
    output logic [7:0]                     awlen,
    output logic [2:0]                     awsize,
    output logic [1:0]                     awburst,
    output logic                           awvalid,
    input  logic                           awready,
    output logic [3:0]                     wid,
    output logic [31:0]                    wdata,
    output logic [3:0]                     wstrb,
    output logic                           wlast,
    output logic                           wvalid,
    input  logic                           wready,
    input  logic                           bvalid,
    output logic                           bready
);

    localparam int GW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    if (LW != $clog2(MAX_LEN) || NUM_PORTS < 1 || NUM_PORTS > 8) begin : g_param_check
        $error("axi_mem_arbiter: bad NUM_PORTS/MAX_LEN/LW combination");
    end

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        AR   = 3'd1,
        R    = 3'd2,
        AW   = 3'd3,
        W    = 3'd4,
        B    = 3'd5
    } state_t;

    state_t          state, state_nxt;
    logic [GW-1:0]   grant, rr_ptr, pick, grant_inc;
    logic            pick_vld;
    logic [31:0]     lat_addr;
    logic [2:0]      lat_size;
    logic [LW-1:0]   lat_len, beat;
    logic [3:0]      lat_strb;
    logic            done;

    // Scan from the highest offset down so the requester closest to rr_ptr wins.
    always_comb begin
        pick_vld = 1'b0;
        pick     = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (p_req[(int'(rr_ptr) + i) % NUM_PORTS]) begin
                pick_vld = 1'b1;
                pick     = GW'((int'(rr_ptr) + i) % NUM_PORTS);
            end
        end
    end

    assign grant_inc = (grant == GW'(NUM_PORTS - 1)) ? '0 : grant + 1'b1;

    always_comb begin
        state_nxt = state;
        arvalid   = 1'b0;
        rready    = 1'b0;
        awvalid   = 1'b0;
        wvalid    = 1'b0;
        wlast     = 1'b0;
        bready    = 1'b0;
        p_wnext   = '0;
        p_rvalid  = '0;
        p_done    = '0;
        done      = 1'b0;
        case (state)
            IDLE: if (pick_vld) state_nxt = p_write[pick] ? AW : AR;
            AR: begin
                arvalid = 1'b1;
                if (arready) state_nxt = R;
            end
            R: begin
                rready = 1'b1;
                if (rvalid) begin
                    p_rvalid[grant] = 1'b1;
                    if (rlast) begin
                        p_done[grant] = 1'b1;
                        done          = 1'b1;
                        state_nxt     = IDLE;
                    end
                end
            end
            AW: begin
                awvalid = 1'b1;
                if (awready) state_nxt = W;
            end
            W: begin
                wvalid = 1'b1;
                wlast  = (beat == lat_len);
                if (wready) begin
                    p_wnext[grant] = 1'b1;
                    if (wlast) state_nxt = B;
                end
            end
            B: begin
                bready = 1'b1;
                if (bvalid) begin
                    p_done[grant] = 1'b1;
                    done          = 1'b1;
                    state_nxt     = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Address-channel buses only carry the latched fields while their valid is up.
    assign arid    = 4'(grant);
    assign awid    = 4'(grant);
    assign wid     = 4'(grant);
    assign arburst = 2'b01;
    assign awburst = 2'b01;
    assign araddr  = arvalid ? lat_addr : '0;
    assign arlen   = arvalid ? 8'(lat_len) : '0;
    assign arsize  = arvalid ? lat_size : '0;
    assign awaddr  = awvalid ? lat_addr : '0;
    assign awlen   = awvalid ? 8'(lat_len) : '0;
    assign awsize  = awvalid ? lat_size : '0;
    assign wdata   = wvalid ? p_wdata[grant] : '0;
    assign wstrb   = wvalid ? lat_strb : '0;
    assign p_rdata = (rready && rvalid) ? rdata : '0;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state    <= IDLE;
            grant    <= '0;
            rr_ptr   <= '0;
            beat     <= '0;
            lat_addr <= '0;
            lat_size <= '0;
            lat_len  <= '0;
            lat_strb <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && pick_vld) begin
                grant    <= pick;
                lat_addr <= p_addr[pick];
                lat_size <= p_size[pick];
                lat_len  <= p_len[pick];
                lat_strb <= p_strb[pick];
                beat     <= '0;
            end
            if (wvalid && wready) beat <= wlast ? '0 : beat + 1'b1;
            if (done) rr_ptr <= grant_inc;
        end
    end

endmodule
